median_window_scheduler: RTL and testbench

Frame-level controller for the multi-kernel median datapath. Arms on a start request, latches one kernel size (3x3/5x5/7x7/9x9) for the whole frame and forwards only that filter's pixel stream. Counts exactly ROWS*COLS output pixels, then pulses frame-done. It sits between the median processing block's four median/done pairs and the downstream pixel sink, giving the sink a single registered stream with frame framing and status.

---
 rtl/median_window_scheduler_if.sv | 34 +++
 rtl/median_window_scheduler.sv | 139 +++++++++++++
 tb/tb_median_window_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_scheduler_if.sv
// Pixel/handshake bundle between the four median filters, the frame scheduler and the pixel sink.
// master: filter/controller side that drives the scheduler; slave: the scheduler itself.
interface median_window_scheduler_if;
  logic       start_i;
  logic [1:0] ksize_i;
  logic [7:0] m_3x3_i;
  logic [7:0] m_5x5_i;
  logic [7:0] m_7x7_i;
  logic [7:0] m_9x9_i;
  logic       done_3x3_i;
  logic       done_5x5_i;
  logic       done_7x7_i;
  logic       done_9x9_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_done_o;
  logic       busy_o;
  logic [1:0] ksize_o;
  logic       abort_o;

  modport master (
    output start_i, ksize_i,
    output m_3x3_i, m_5x5_i, m_7x7_i, m_9x9_i,
    output done_3x3_i, done_5x5_i, done_7x7_i, done_9x9_i,
    input  data_o, valid_o, frame_done_o, busy_o, ksize_o, abort_o
  );

  modport slave (
    input  start_i, ksize_i,
    input  m_3x3_i, m_5x5_i, m_7x7_i, m_9x9_i,
    input  done_3x3_i, done_5x5_i, done_7x7_i, done_9x9_i,
    output data_o, valid_o, frame_done_o, busy_o, ksize_o, abort_o
  );
endinterface

// File: rtl/median_window_scheduler.sv
// Frame scheduler: latches one kernel size per frame, forwards ROWS*COLS pixels, pulses frame done.
// Optional watchdog abort enabled by defining MEDIAN_SCHED_TIMEOUT_EN.
module median_window_scheduler #(
  parameter int unsigned COLS    = 30,
  parameter int unsigned ROWS    = 30,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                      clk,
  input logic                      rst,
  median_window_scheduler_if.slave bus_io
);

  localparam int unsigned Total = ROWS * COLS;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam logic [CntW-1:0] CntTotal = CntW'(Total);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
  localparam logic [2:0] StAbort  = 3'd4;
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdTimeout = WdW'(TIMEOUT);
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      ksize_q, ksize_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            sel_done;
  logic [7:0]      sel_med;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
  logic [WdW-1:0]  wd_q, wd_d;
`endif

  always_comb begin
    sel_done = 1'b0;
    sel_med  = 8'd0;
    unique case (ksize_q)
      2'd0: begin sel_done = bus_io.done_3x3_i; sel_med = bus_io.m_3x3_i; end
      2'd1: begin sel_done = bus_io.done_5x5_i; sel_med = bus_io.m_5x5_i; end
      2'd2: begin sel_done = bus_io.done_7x7_i; sel_med = bus_io.m_7x7_i; end
      2'd3: begin sel_done = bus_io.done_9x9_i; sel_med = bus_io.m_9x9_i; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ksize_d = ksize_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      // DONE also samples start so a new frame can chain without a dead cycle.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus_io.start_i) begin
          ksize_d = bus_io.ksize_i;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (sel_done) begin
          data_d  = sel_med;
          valid_d = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StStream;
        end
      end
      StStream: begin
        // One extra cycle here keeps frame_done one cycle behind the last valid.
        if (cnt_q == CntTotal) begin
          state_d = StDone;
        end else if (sel_done) begin
          data_d  = sel_med;
          valid_d = 1'b1;
          cnt_d   = cnt_q + CntW'(1);
        end
      end
`ifdef MEDIAN_SCHED_TIMEOUT_EN
      StAbort: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase

`ifdef MEDIAN_SCHED_TIMEOUT_EN
    wd_d = '0;
    if (state_q == StWait || (state_q == StStream && cnt_q != CntTotal)) begin
      // Counts cycles since the last selected strobe; a strobe restarts the count at 1.
      if (sel_done) begin
        wd_d = WdW'(1);
      end else begin
        wd_d = wd_q + WdW'(1);
        if (wd_d == WdTimeout) state_d = StAbort;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ksize_q <= 2'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ksize_q <= ksize_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef MEDIAN_SCHED_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus_io.data_o       = data_q;
  assign bus_io.valid_o      = valid_q;
  assign bus_io.frame_done_o = (state_q == StDone);
  assign bus_io.busy_o       = (state_q == StWait) || (state_q == StStream);
  assign bus_io.ksize_o      = ksize_q;

`ifdef MEDIAN_SCHED_TIMEOUT_EN
  assign bus_io.abort_o = (state_q == StAbort);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus_io.abort_o = 1'b0;
`endif

endmodule

// File: tb/tb_median_window_scheduler.sv
// Randomized self-checking bench for median_window_scheduler (4x4 frame, TIMEOUT=8).
// Expected outputs come from frame-level rules: valid one cycle after each of the first
// ROWS*COLS selected strobes, frame_done two cycles after the last one.
module tb_median_window_scheduler;

  localparam int TOTAL = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  median_window_scheduler_if bus ();

  median_window_scheduler #(
    .COLS    (4),
    .ROWS    (4),
    .TIMEOUT (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic st, input logic [1:0] ks, input logic [3:0] dn,
                       input logic [31:0] md);
    bus.start_i    = st;
    bus.ksize_i    = ks;
    bus.done_3x3_i = dn[0];
    bus.done_5x5_i = dn[1];
    bus.done_7x7_i = dn[2];
    bus.done_9x9_i = dn[3];
    bus.m_3x3_i    = md[7:0];
    bus.m_5x5_i    = md[15:8];
    bus.m_7x7_i    = md[23:16];
    bus.m_9x9_i    = md[31:24];
  endtask

  // One frame: cycle 0 drives start; strobes on the selected filter with 0..gap_max idle gaps.
  task automatic run_frame(input logic [1:0] k, input int gap_max, input bit iso, input bit seq,
                           input bit poke, input bit chain_in, input bit chain_out);
    int          sel_cnt, gap, last, nvalid, nfd;
    bit          fwd, fwd_prev, finished;
    logic        exp_fd, exp_busy;
    logic [7:0]  med_prev;
    logic [3:0]  dn;
    logic [31:0] md;
    logic        st;
    logic [1:0]  ks;
    sel_cnt  = 0;
    gap      = $urandom_range(gap_max);
    last     = -1;
    nvalid   = 0;
    nfd      = 0;
    fwd_prev = 1'b0;
    med_prev = 8'd0;
    finished = 1'b0;
    for (int c = 0; c < 400 && !finished; c++) begin
      if (!(chain_in && c == 0)) begin
        @(negedge clk);
        exp_fd   = (last >= 0) && (c == last + 2);
        exp_busy = (c >= 1) && ((last < 0) || (c <= last + 1));
        n_checks++;
        if (bus.valid_o !== fwd_prev) begin
          n_fail++;
          $display("FAIL frame_valid k=%0d cycle %0d: got %b want %b", k, c, bus.valid_o, fwd_prev);
        end
        if (fwd_prev) begin
          n_checks++;
          if (bus.data_o !== med_prev) begin
            n_fail++;
            $display("FAIL frame_data k=%0d cycle %0d: got %h want %h", k, c, bus.data_o, med_prev);
          end
        end
        n_checks++;
        if (bus.frame_done_o !== exp_fd) begin
          n_fail++;
          $display("FAIL frame_done k=%0d cycle %0d: got %b want %b", k, c, bus.frame_done_o,
                   exp_fd);
        end
        n_checks++;
        if (bus.busy_o !== exp_busy) begin
          n_fail++;
          $display("FAIL frame_busy k=%0d cycle %0d: got %b want %b", k, c, bus.busy_o, exp_busy);
        end
        if (c >= 1) begin
          n_checks++;
          if (bus.ksize_o !== k) begin
            n_fail++;
            $display("FAIL frame_ksize cycle %0d: got %0d want %0d", c, bus.ksize_o, k);
          end
        end
        n_checks++;
        if (bus.abort_o !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_abort cycle %0d: got %b want 0", c, bus.abort_o);
        end
        if (bus.valid_o === 1'b1) nvalid++;
        if (bus.frame_done_o === 1'b1) nfd++;
      end

      if (last >= 0 && c == last + (chain_out ? 2 : 3)) begin
        finished = 1'b1;
        n_checks++;
        if (nvalid != TOTAL) begin
          n_fail++;
          $display("FAIL valid_count k=%0d: got %0d want %0d", k, nvalid, TOTAL);
        end
        n_checks++;
        if (nfd != 1) begin
          n_fail++;
          $display("FAIL frame_done_count k=%0d: got %0d want 1", k, nfd);
        end
        if (!chain_out) drive(1'b0, 2'd0, 4'd0, 32'd0);
      end else begin
        fwd = 1'b0;
        if (c >= 1 && sel_cnt < TOTAL) begin
          if (gap == 0) begin
            fwd = 1'b1;
            sel_cnt++;
            gap = $urandom_range(gap_max);
            if (sel_cnt == TOTAL) last = c;
          end else begin
            gap--;
          end
        end
        md = $urandom;
        if (iso) begin
          md[7:0]   = 8'h11;
          md[31:24] = 8'hAA;
        end
        if (seq && fwd) md[8*k +: 8] = 8'(sel_cnt - 1);
        dn = iso ? 4'hF : 4'($urandom);
        if (c >= 1 && (last < 0 || c == last)) dn[k] = fwd;
        st = (c == 0);
        ks = (c == 0) ? k : 2'($urandom);
        if (poke && c >= 1 && last < 0 && $urandom_range(3) == 0) begin
          st = 1'b1;
          ks = 2'd0;
        end
        drive(st, ks, dn, md);
        fwd_prev = fwd;
        med_prev = md[8*k +: 8];
      end
    end
    if (!finished) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_timeout k=%0d: got no frame end want frame end within 400 cycles", k);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'd0, 32'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.data_o, bus.valid_o, bus.frame_done_o, bus.busy_o, bus.ksize_o, bus.abort_o}
        !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h valid=%b fd=%b busy=%b ks=%0d abort=%b want all 0",
               bus.data_o, bus.valid_o, bus.frame_done_o, bus.busy_o, bus.ksize_o, bus.abort_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    run_frame(2'd1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_select_isolation;
    run_frame(2'd3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_guards;
    run_frame(2'd2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(2'd1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    drive(1'b1, 2'd2, 4'd0, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 4'b0100, {8'd0, 8'(i), 16'd0});
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 4'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.data_o, bus.valid_o, bus.frame_done_o, bus.busy_o, bus.ksize_o, bus.abort_o}
        !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got data=%h valid=%b fd=%b busy=%b ks=%0d abort=%b want 0",
               bus.data_o, bus.valid_o, bus.frame_done_o, bus.busy_o, bus.ksize_o, bus.abort_o);
    end
    run_frame(2'd2, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_gapped;
    for (int f = 0; f < 3; f++) run_frame(2'($urandom), 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef MEDIAN_SCHED_TIMEOUT_EN
  task automatic test_watchdog;
    int naborts;
    naborts = 0;
    @(negedge clk);
    drive(1'b1, 2'd0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 4'b0001, 32'h5A);
    end
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 4'd0, 32'd0);
      n_checks++;
      if (bus.abort_o !== (j == 8)) begin
        n_fail++;
        $display("FAIL wd_abort +%0d: got %b want %b", j, bus.abort_o, (j == 8));
      end
      n_checks++;
      if (bus.busy_o !== (j < 8)) begin
        n_fail++;
        $display("FAIL wd_busy +%0d: got %b want %b", j, bus.busy_o, (j < 8));
      end
      n_checks++;
      if (bus.frame_done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_frame_done +%0d: got %b want 0", j, bus.frame_done_o);
      end
      if (bus.abort_o === 1'b1) naborts++;
    end
    n_checks++;
    if (naborts != 1) begin
      n_fail++;
      $display("FAIL wd_abort_count: got %0d want 1", naborts);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_select_isolation();
    test_restart_guards();
    test_reset_mid_frame();
    test_gapped();
`ifdef MEDIAN_SCHED_TIMEOUT_EN
    test_watchdog();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
